// File: rtl/coproc_sequencer.sv
// Instruction sequencer for the matrix coprocessor: fetches 15-bit instructions,
// reads operands, launches the ALU and writes the result back through one memory port.
module coproc_sequencer #(
   parameter logic [7:0]  PROG_BASE   = 8'h00,
   parameter int unsigned MEM_LAT     = 1,
   parameter int unsigned ALU_TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   output logic [7:0]   mem_address,
   output logic         mem_wren,
   output logic [199:0] mem_wdata,
   input  logic [199:0] mem_rdata,
   output logic [3:0]   alu_op,
   output logic [2:0]   alu_size,
   output logic [199:0] alu_a,
   output logic [199:0] alu_b,
   output logic         alu_start,
   input  logic         alu_done,
   input  logic [199:0] alu_result,
   input  logic         alu_ovf,
   output logic [7:0]   pc,
   output logic         busy,
   output logic         halted,
   output logic         error,
   output logic         ovf_flag
);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_RD_A, S_RD_B,
      S_EXEC, S_EXEC_WAIT, S_WB, S_NEXT, S_HALTED
   } state_t;

   localparam logic [3:0] OP_NOP  = 4'd7;
   localparam logic [3:0] OP_HALT = 4'd15;

   state_t         state_q;
   logic [7:0]     pc_q;
   logic [7:0]     addr_q;
   logic           wren_q;
   logic [199:0]   wdata_q;
   logic [3:0]     op_q;
   logic [2:0]     size_q;
   logic [7:0]     base_q;
   logic [199:0]   a_q;
   logic [199:0]   b_q;
   logic           astart_q;
   logic           error_q;
   logic           ovf_q;
   logic           start_q;
   logic [1:0]     wait_q;
   logic [8:0]     tmo_q;

   logic           start_edge;
   logic           mem_ready;
   logic           is_unary;
   logic           is_illegal;
   logic [8:0]     tmo_d;
   logic           tmo_hit;

   assign start_edge = start & ~start_q;
   assign mem_ready  = (wait_q == 2'(MEM_LAT));
   assign is_unary   = (op_q == 4'd4) || (op_q == 4'd5) || (op_q == 4'd6);
   assign is_illegal = (op_q >= 4'd8) && (op_q <= 4'd14);
   // tmo_q holds cycles elapsed since alu_start rose; tmo_d is the count at this edge
   assign tmo_d      = tmo_q + 9'd1;
   assign tmo_hit    = (32'(tmo_d) >= ALU_TIMEOUT);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         pc_q     <= PROG_BASE;
         addr_q   <= 8'h00;
         wren_q   <= 1'b0;
         wdata_q  <= '0;
         op_q     <= 4'd0;
         size_q   <= 3'd0;
         base_q   <= 8'h00;
         a_q      <= '0;
         b_q      <= '0;
         astart_q <= 1'b0;
         error_q  <= 1'b0;
         ovf_q    <= 1'b0;
         start_q  <= 1'b0;
         wait_q   <= 2'd0;
         tmo_q    <= 9'd0;
      end else begin
         start_q  <= start;
         // NOTE: pulse outputs default low every cycle; only the entering transition raises them.
         wren_q   <= 1'b0;
         astart_q <= 1'b0;

         case (state_q)
            S_IDLE, S_HALTED: begin
               if (start_edge) begin
                  state_q <= S_FETCH;
                  pc_q    <= PROG_BASE;
                  addr_q  <= PROG_BASE;
                  wait_q  <= 2'd0;
                  error_q <= 1'b0;
                  ovf_q   <= 1'b0;
               end
            end

            S_FETCH: begin
               if (mem_ready) begin
                  op_q    <= mem_rdata[14:11];
                  size_q  <= mem_rdata[10:8];
                  base_q  <= mem_rdata[7:0];
                  state_q <= S_DECODE;
               end else begin
                  wait_q <= wait_q + 2'd1;
               end
            end

            S_DECODE: begin
               wait_q <= 2'd0;
               if (is_illegal) begin
                  error_q <= 1'b1;
                  state_q <= S_HALTED;
               end else if (op_q == OP_HALT) begin
                  state_q <= S_HALTED;
               end else if (op_q == OP_NOP) begin
                  state_q <= S_NEXT;
               end else begin
                  addr_q  <= base_q;
                  if (is_unary) b_q <= '0;
                  state_q <= S_RD_A;
               end
            end

            S_RD_A: begin
               if (mem_ready) begin
                  a_q    <= mem_rdata;
                  wait_q <= 2'd0;
                  if (is_unary) begin
                     astart_q <= 1'b1;
                     state_q  <= S_EXEC;
                  end else begin
                     addr_q  <= base_q + 8'd1;
                     state_q <= S_RD_B;
                  end
               end else begin
                  wait_q <= wait_q + 2'd1;
               end
            end

            S_RD_B: begin
               if (mem_ready) begin
                  b_q      <= mem_rdata;
                  astart_q <= 1'b1;
                  state_q  <= S_EXEC;
               end else begin
                  wait_q <= wait_q + 2'd1;
               end
            end

            S_EXEC: begin
               tmo_q   <= 9'd1;
               state_q <= S_EXEC_WAIT;
            end

            S_EXEC_WAIT: begin
               // A completion arriving on the timeout cycle takes priority over the abort
               if (alu_done) begin
                  wdata_q <= alu_result;
                  ovf_q   <= ovf_q | alu_ovf;
                  addr_q  <= base_q + 8'd2;
                  wren_q  <= 1'b1;
                  state_q <= S_WB;
               end else if (tmo_hit) begin
                  error_q <= 1'b1;
                  state_q <= S_HALTED;
               end else begin
                  tmo_q <= tmo_d;
               end
            end

            S_WB: state_q <= S_NEXT;

            S_NEXT: begin
               pc_q    <= pc_q + 8'd1;
               addr_q  <= pc_q + 8'd1;
               wait_q  <= 2'd0;
               state_q <= S_FETCH;
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_address = addr_q;
   assign mem_wren    = wren_q;
   assign mem_wdata   = wdata_q;
   assign alu_op      = op_q;
   assign alu_size    = size_q;
   assign alu_a       = a_q;
   assign alu_b       = b_q;
   assign alu_start   = astart_q;
   assign pc          = pc_q;
   assign busy        = (state_q != S_IDLE) && (state_q != S_HALTED);
   assign halted      = (state_q == S_HALTED);
   assign error       = error_q;
   assign ovf_flag    = ovf_q;

endmodule

// File: tb/tb_coproc_sequencer.sv
// Directed bench for coproc_sequencer: synchronous memory and 1-cycle ALU models
// with hand-computed expectations per scenario.
module tb_coproc_sequencer;

   logic         clk = 1'b0;
   logic         reset, start;
   logic [7:0]   mem_address;
   logic         mem_wren;
   logic [199:0] mem_wdata, mem_rdata;
   logic [3:0]   alu_op;
   logic [2:0]   alu_size;
   logic [199:0] alu_a, alu_b, alu_result;
   logic         alu_start, alu_done, alu_done_m, alu_ovf;
   logic [7:0]   pc;
   logic         busy, halted, error, ovf_flag;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   coproc_sequencer #(.PROG_BASE(8'h00), .MEM_LAT(1), .ALU_TIMEOUT(8)) dut (
      .clk(clk), .reset(reset), .start(start),
      .mem_address(mem_address), .mem_wren(mem_wren), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .alu_op(alu_op), .alu_size(alu_size), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
      .alu_done(alu_done), .alu_result(alu_result), .alu_ovf(alu_ovf),
      .pc(pc), .busy(busy), .halted(halted), .error(error), .ovf_flag(ovf_flag)
   );

   // Synchronous RAM, one cycle read latency; img is bulk-copied in on load
   logic [199:0] mem [256];
   logic [199:0] img [256];
   logic         load;
   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < 256; i++) mem[i] <= img[i];
      end else if (mem_wren) begin
         mem[mem_address] <= mem_wdata;
      end
      mem_rdata <= mem[mem_address];
   end

   function automatic logic [199:0] alu_model(input logic [3:0] op, input logic [199:0] a, input logic [199:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd4:    return {a[99:0], a[199:100]};
         default: return a ^ b;
      endcase
   endfunction

   // ALU answers one cycle after alu_start; monitor tallies bus activity
   logic         alu_respond, alu_ovf_cfg, force_done, mon_clear;
   logic         pend = 1'b0;
   logic [199:0] pend_res = '0;
   int           wr_cnt, start_cnt, wren_twice;
   int           rd_cnt [256];
   logic [7:0]   last_wr_addr, prev_addr;
   logic [199:0] last_wr_data, b_at_start;
   logic [3:0]   op_at_start;
   logic [2:0]   size_at_start;
   logic         prev_wren;

   assign alu_done = alu_done_m | force_done;

   always @(negedge clk) begin
      alu_done_m = pend && alu_respond;
      alu_result = pend_res;
      alu_ovf    = alu_done_m && alu_ovf_cfg;
      pend       = alu_start;
      if (alu_start) pend_res = alu_model(alu_op, alu_a, alu_b);
      if (mon_clear) begin
         wr_cnt = 0; start_cnt = 0; wren_twice = 0;
         for (int i = 0; i < 256; i++) rd_cnt[i] = 0;
         last_wr_addr = 8'h00; last_wr_data = '0; b_at_start = '0;
         op_at_start = 4'd0; size_at_start = 3'd0;
         prev_addr = mem_address; prev_wren = 1'b0;
      end else begin
         if (mem_wren) begin
            wr_cnt++;
            last_wr_addr = mem_address;
            last_wr_data = mem_wdata;
            if (prev_wren) wren_twice++;
         end else if (mem_address != prev_addr) begin
            rd_cnt[mem_address]++;
         end
         prev_addr = mem_address;
         prev_wren = mem_wren;
         if (alu_start) begin
            start_cnt++;
            b_at_start    = alu_b;
            op_at_start   = alu_op;
            size_at_start = alu_size;
         end
      end
   end

   task automatic load_mem();
      load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
   endtask

   task automatic clear_mon();
      mon_clear = 1'b1;
      @(negedge clk); #1;
      mon_clear = 1'b0;
   endtask

   // Produces a start rising edge, then counts posedges until halted (bounded).
   // poke != 0 drops start for one cycle at that count to try a retrigger while busy.
   task automatic run_prog(input int limit, input int poke, output int n);
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (poke != 0 && n == poke)     start = 1'b0;
         if (poke != 0 && n == poke + 1) start = 1'b1;
      end while (!halted && n < limit);
   endtask

   task automatic test_reset();
      tests_run++; if ({busy, halted, error, ovf_flag, mem_wren, alu_start} !== 6'b0) begin tests_failed++; $display("FAIL reset_flags: got %b expected 000000", {busy, halted, error, ovf_flag, mem_wren, alu_start}); end
      tests_run++; if (pc !== 8'h00) begin tests_failed++; $display("FAIL reset_pc: got %h expected 00", pc); end
      tests_run++; if (mem_address !== 8'h00) begin tests_failed++; $display("FAIL reset_addr: got %h expected 00", mem_address); end
      tests_run++; if ({alu_a, alu_b, mem_wdata} !== 600'b0) begin tests_failed++; $display("FAIL reset_data: alu_a/alu_b/mem_wdata not zero"); end
   endtask

   task automatic test_add();
      int n;
      img[8'h00] = 200'h0210;   // ADD size 2 base 0x10
      img[8'h01] = 200'h7800;   // HALT
      img[8'h10] = 200'd1234;
      img[8'h11] = 200'd4321;
      alu_respond = 1'b1; alu_ovf_cfg = 1'b0;
      load_mem(); clear_mon();
      run_prog(100, 4, n);
      tests_run++; if (n !== 15) begin tests_failed++; $display("FAIL add_cycles: got %0d expected 15", n); end
      tests_run++; if (wr_cnt !== 1) begin tests_failed++; $display("FAIL add_wr_cnt: got %0d expected 1", wr_cnt); end
      tests_run++; if (last_wr_addr !== 8'h12) begin tests_failed++; $display("FAIL add_wr_addr: got %h expected 12", last_wr_addr); end
      tests_run++; if (last_wr_data !== 200'd5555) begin tests_failed++; $display("FAIL add_wr_data: got %0d expected 5555", last_wr_data); end
      tests_run++; if (size_at_start !== 3'd2) begin tests_failed++; $display("FAIL add_size: got %0d expected 2", size_at_start); end
      tests_run++; if ({halted, busy, error, ovf_flag} !== 4'b1000) begin tests_failed++; $display("FAIL add_status: got %b expected 1000", {halted, busy, error, ovf_flag}); end
      tests_run++; if (pc !== 8'h01) begin tests_failed++; $display("FAIL add_pc: got %h expected 01", pc); end
      repeat (5) @(posedge clk);
      #1;
      tests_run++; if ({halted, pc} !== {1'b1, 8'h01}) begin tests_failed++; $display("FAIL add_hold_start: got halted=%b pc=%h expected halted=1 pc=01", halted, pc); end
   endtask

   task automatic test_transpose();
      int n;
      img[8'h00] = 200'h2120;   // TRANSPOSE size 1 base 0x20
      img[8'h01] = 200'h7800;
      img[8'h20] = {100'hA5, 100'h3C};
      img[8'h21] = 200'hDEAD;
      alu_respond = 1'b1; alu_ovf_cfg = 1'b1;
      load_mem(); clear_mon();
      run_prog(100, 0, n);
      tests_run++; if (rd_cnt[8'h20] !== 1) begin tests_failed++; $display("FAIL tr_read_a: got %0d expected 1", rd_cnt[8'h20]); end
      tests_run++; if (rd_cnt[8'h21] !== 0) begin tests_failed++; $display("FAIL tr_read_b: got %0d expected 0", rd_cnt[8'h21]); end
      tests_run++; if (b_at_start !== 200'b0) begin tests_failed++; $display("FAIL tr_alu_b: got %h expected 0", b_at_start); end
      tests_run++; if (op_at_start !== 4'd4) begin tests_failed++; $display("FAIL tr_op: got %0d expected 4", op_at_start); end
      tests_run++; if ({wr_cnt, last_wr_addr} !== {32'd1, 8'h22}) begin tests_failed++; $display("FAIL tr_write: got cnt=%0d addr=%h expected cnt=1 addr=22", wr_cnt, last_wr_addr); end
      tests_run++; if (last_wr_data !== {100'h3C, 100'hA5}) begin tests_failed++; $display("FAIL tr_data: got %h expected swapped halves", last_wr_data); end
      tests_run++; if ({halted, ovf_flag} !== 2'b11) begin tests_failed++; $display("FAIL tr_ovf: got halted=%b ovf=%b expected 1 1", halted, ovf_flag); end
   endtask

   task automatic test_illegal();
      int n;
      img[8'h00] = 200'h4800;   // opcode 9
      alu_respond = 1'b1; alu_ovf_cfg = 1'b0;
      load_mem(); clear_mon();
      run_prog(100, 0, n);
      tests_run++; if ({halted, error, ovf_flag} !== 3'b110) begin tests_failed++; $display("FAIL ill_status: got %b expected 110", {halted, error, ovf_flag}); end
      tests_run++; if ({wr_cnt, start_cnt} !== {32'd0, 32'd0}) begin tests_failed++; $display("FAIL ill_activity: got wr=%0d start=%0d expected 0 0", wr_cnt, start_cnt); end
      tests_run++; if (pc !== 8'h00) begin tests_failed++; $display("FAIL ill_pc: got %h expected 00", pc); end
   endtask

   task automatic test_timeout();
      int n, m;
      img[8'h00] = 200'h0030;   // ADD base 0x30
      img[8'h01] = 200'h7800;
      alu_respond = 1'b0;
      load_mem(); clear_mon();
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1;
      n = 0;
      while (!alu_start && n < 50) begin @(negedge clk); n++; end
      tests_run++; if (alu_start !== 1'b1) begin tests_failed++; $display("FAIL to_launch: alu_start not seen within 50 cycles"); end
      m = 0;
      do begin @(negedge clk); m++; end while (!halted && m < 50);
      tests_run++; if (m !== 8) begin tests_failed++; $display("FAIL to_cycles: got %0d expected 8", m); end
      tests_run++; if ({halted, error} !== 2'b11) begin tests_failed++; $display("FAIL to_status: got %b expected 11", {halted, error}); end
      tests_run++; if (wr_cnt !== 0) begin tests_failed++; $display("FAIL to_write: got %0d expected 0", wr_cnt); end
      alu_respond = 1'b1;
   endtask

   task automatic test_wrap();
      int n;
      for (int i = 0; i < 8'hFD; i++) img[i] = 200'h3800;   // NOP
      img[8'hFD] = 200'h00FE;   // ADD base 0xFE -> writes 0x00
      img[8'hFE] = 200'h3F00;   // NOP, also operand A
      img[8'hFF] = 200'h3900;   // NOP, also operand B; A+B = 0x7800 (HALT)
      alu_respond = 1'b1; alu_ovf_cfg = 1'b0;
      load_mem(); clear_mon();
      run_prog(3000, 0, n);
      tests_run++; if ({wr_cnt, last_wr_addr} !== {32'd1, 8'h00}) begin tests_failed++; $display("FAIL wrap_write: got cnt=%0d addr=%h expected cnt=1 addr=00", wr_cnt, last_wr_addr); end
      tests_run++; if (last_wr_data !== 200'h7800) begin tests_failed++; $display("FAIL wrap_data: got %h expected 7800", last_wr_data); end
      tests_run++; if ({halted, error, pc} !== {2'b10, 8'h00}) begin tests_failed++; $display("FAIL wrap_end: got halted=%b error=%b pc=%h expected 1 0 00", halted, error, pc); end
      tests_run++; if (wren_twice !== 0) begin tests_failed++; $display("FAIL wrap_wren_pulse: got %0d back-to-back writes expected 0", wren_twice); end
   endtask

   task automatic test_reset_mid_op();
      int n;
      img[8'h00] = 200'h0210;
      img[8'h01] = 200'h7800;
      img[8'h10] = 200'd7;
      img[8'h11] = 200'd8;
      alu_respond = 1'b0;
      load_mem(); clear_mon();
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1;
      n = 0;
      while (!alu_start && n < 50) begin @(negedge clk); n++; end
      tests_run++; if (alu_start !== 1'b1) begin tests_failed++; $display("FAIL rst_launch: alu_start not seen within 50 cycles"); end
      @(negedge clk); #1;
      reset = 1'b0; start = 1'b0;
      @(negedge clk); #1;
      reset = 1'b1; force_done = 1'b1;
      @(posedge clk); #1;
      force_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++; if ({busy, halted, error, mem_wren, alu_start} !== 5'b0) begin tests_failed++; $display("FAIL rst_flags: got %b expected 00000", {busy, halted, error, mem_wren, alu_start}); end
      tests_run++; if ({pc, mem_address} !== 16'h0000) begin tests_failed++; $display("FAIL rst_regs: got pc=%h addr=%h expected 00 00", pc, mem_address); end
      tests_run++; if ({alu_a, alu_b} !== 400'b0) begin tests_failed++; $display("FAIL rst_operands: alu_a/alu_b not zero"); end
      tests_run++; if (wr_cnt !== 0) begin tests_failed++; $display("FAIL rst_no_write: got %0d expected 0", wr_cnt); end
      alu_respond = 1'b1;
      clear_mon();
      run_prog(100, 0, n);
      tests_run++; if ({wr_cnt, last_wr_addr} !== {32'd1, 8'h12}) begin tests_failed++; $display("FAIL rst_rerun_write: got cnt=%0d addr=%h expected cnt=1 addr=12", wr_cnt, last_wr_addr); end
      tests_run++; if (last_wr_data !== 200'd15) begin tests_failed++; $display("FAIL rst_rerun_data: got %0d expected 15", last_wr_data); end
      tests_run++; if ({halted, pc} !== {1'b1, 8'h01}) begin tests_failed++; $display("FAIL rst_rerun_end: got halted=%b pc=%h expected 1 01", halted, pc); end
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; load = 1'b0; mon_clear = 1'b1;
      force_done = 1'b0; alu_respond = 1'b1; alu_ovf_cfg = 1'b0;
      for (int i = 0; i < 256; i++) img[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      mon_clear = 1'b0;
      test_reset();
      test_add();
      test_transpose();
      test_illegal();
      test_timeout();
      test_wrap();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
